reset_seq: RTL and testbench
============================

RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 Parameter N_OUT, default 2, number of sequenced reset outputs (legal 1..8).
REQ-002 Parameter CNT_W, default 8, width of the shared delay counter.
REQ-003 Parameter SETTLE_CYC, default 16, cycles of stable lock before the first release (legal 1..2^CNT_W-1).
REQ-004 Parameter STAGE_CYC, default 4, cycles between successive releases (legal 1..2^CNT_W-1).
REQ-005 clk25  input  1  system clock, all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 lock  input  1  PLL lock, asynchronous to clk25.
REQ-008 soft_rst  input  1  synchronous request, one-cycle pulse, restarts the sequence.
REQ-009 rst_out  output  N_OUT  active-high domain resets; bit 0 is released first.
REQ-010 ready  output  1  high only while every rst_out bit is low.
REQ-011 lost_cnt  output  4  saturating count of lock-loss events.

Function
REQ-012 lock SHALL pass through a 2-flop synchronizer to give lock_s; lock sampled high at edge k SHALL make lock_s high after edge k+1.
REQ-013 FSM states SHALL be WAIT_LOCK, SETTLE, RELEASE and RUN; all outputs SHALL be registered.
REQ-014 WAIT_LOCK: all rst_out=1, ready=0; when lock_s=1, next state SHALL be SETTLE with cnt=0.
REQ-015 SETTLE: cnt SHALL increment each cycle; the edge that sees cnt==SETTLE_CYC-1 SHALL clear rst_out[0] and load cnt=0, stage=1.
REQ-016 On that edge the next state SHALL be RELEASE if N_OUT>1; if N_OUT==1 it SHALL be RUN with ready=1.
REQ-017 RELEASE: the edge that sees cnt==STAGE_CYC-1 SHALL clear rst_out[stage], zero cnt and increment stage.
REQ-018 The edge that clears rst_out[N_OUT-1] SHALL also set ready=1 and enter RUN.
REQ-019 rst_out bits SHALL only fall in index order; no bit SHALL fall before all lower bits are low.
REQ-020 Lock loss (lock_s=0 in SETTLE, RELEASE or RUN) SHALL, on the next edge, set all rst_out=1 and ready=0, enter WAIT_LOCK, and increment lost_cnt, saturating at 15.
REQ-021 A lock-loss event therefore SHALL assert resets at edge j+2 when lock is sampled low at edge j.
REQ-022 soft_rst=1 in SETTLE, RELEASE or RUN SHALL, on the next edge, set all rst_out=1 and ready=0, and enter SETTLE with cnt=0; lost_cnt SHALL be unchanged.
REQ-023 soft_rst SHALL be ignored in WAIT_LOCK.
REQ-024 If lock loss and soft_rst occur in the same cycle, lock loss SHALL win.
REQ-025 A lock_s low of any duration of at least one cycle SHALL count as one loss event; there is no glitch filter.
REQ-026 cnt SHALL never wrap; it SHALL be zeroed on every state change.

Reset
REQ-027 rst_n low SHALL asynchronously force rst_out to all ones, ready=0, state WAIT_LOCK, cnt=0, stage=0, lost_cnt=0 and both synchronizer flops to 0.
REQ-028 After rst_n rises, the block SHALL start from WAIT_LOCK regardless of lock.
REQ-029 rst_n asserted mid-sequence SHALL abort the sequence with no partial release held.

Structure
REQ-030 The FSM state encoding and the legal-range limits for N_OUT and CNT_W SHALL live in shared package sys_pkg.
REQ-031 The synchronizer SHALL be the sub-module sync2 (2-flop, async active-low clear), reusable for soft inputs elsewhere.
REQ-032 Illegal parameter values SHALL cause an elaboration-time error.

Verification
REQ-033 Defaults, rst_n released, lock sampled high at edge k -> rst_out[0] falls at k+18, rst_out[1] and ready at k+22.
REQ-034 N_OUT=1, SETTLE_CYC=1, lock high at edge k -> rst_out[0] falls and ready rises at k+3; no RELEASE state is entered.
REQ-035 Lock drops for 1 cycle at edge j in RUN -> all rst_out=1 at j+2, lost_cnt 0->1, full sequence repeats after lock_s recovers.
REQ-036 soft_rst pulse in RUN at edge m with lock steady -> all rst_out=1 at m+1, rst_out[0] falls at m+17, ready at m+21, lost_cnt unchanged.
REQ-037 soft_rst and lock loss in the same cycle during RELEASE -> state WAIT_LOCK and lost_cnt incremented; 20 loss events -> lost_cnt holds at 15.
REQ-038 rst_n pulsed low mid-RELEASE with rst_out=2'b10 -> rst_out=2'b11, ready=0 and lost_cnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sys_pkg.sv
// Shared definitions for the reset sequencer: FSM encoding, legal parameter
// ranges and the saturating loss-counter helper.
package sys_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      SETTLE    = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } rs_state_e;

   localparam int unsigned N_OUT_MIN = 1;
   localparam int unsigned N_OUT_MAX = 8;
   localparam int unsigned CNT_W_MIN = 1;
   localparam int unsigned CNT_W_MAX = 16;

   localparam logic [3:0] LOST_SAT = 4'hF;

   // Increment a 4-bit event count, holding at LOST_SAT.
   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == LOST_SAT) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/reset_seq_if.sv
// Reset sequencer bus: PLL lock and soft-reset requests in, sequenced
// domain resets, ready flag and lock-loss count out.
interface reset_seq_if #(
   parameter int unsigned N_OUT = 2
) ();

   logic             lock;
   logic             soft_rst;
   logic [N_OUT-1:0] rst_out;
   logic             ready;
   logic [3:0]       lost_cnt;

   modport master (
      output lock,
      output soft_rst,
      input  rst_out,
      input  ready,
      input  lost_cnt
   );

   modport slave (
      input  lock,
      input  soft_rst,
      output rst_out,
      output ready,
      output lost_cnt
   );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer with asynchronous active-low clear; the output is
// low while in reset and follows i_d two rising edges later.
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // Shift the asynchronous input through two flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer: waits for a synchronized PLL lock, lets it settle, then
// releases the domain resets one at a time in index order. Lock loss or a
// soft reset request re-asserts every domain reset.
module reset_seq
   import sys_pkg::*;
#(
   parameter int unsigned N_OUT      = 2,
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned SETTLE_CYC = 16,
   parameter int unsigned STAGE_CYC  = 4
) (
   input  logic       clk25,
   input  logic       rst_n,
   reset_seq_if.slave bus
);

   localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

   if (N_OUT < N_OUT_MIN || N_OUT > N_OUT_MAX) begin : g_bad_n_out
      $error("reset_seq: N_OUT=%0d outside legal range", N_OUT);
   end
   if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
      $error("reset_seq: CNT_W=%0d outside legal range", CNT_W);
   end
   if (SETTLE_CYC < 1 || 64'(SETTLE_CYC) > CNT_MAX) begin : g_bad_settle
      $error("reset_seq: SETTLE_CYC=%0d does not fit the counter", SETTLE_CYC);
   end
   if (STAGE_CYC < 1 || 64'(STAGE_CYC) > CNT_MAX) begin : g_bad_stage
      $error("reset_seq: STAGE_CYC=%0d does not fit the counter", STAGE_CYC);
   end

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] STAGE_LAST  = CNT_W'(STAGE_CYC - 1);
   localparam logic [3:0]       LAST_STAGE  = 4'(N_OUT - 1);

   rs_state_e        r_state;
   rs_state_e        w_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt;
   logic [3:0]       r_stage;
   logic [3:0]       w_stage;
   logic [N_OUT-1:0] r_rst_out;
   logic [N_OUT-1:0] w_rst_out;
   logic             r_ready;
   logic             w_ready;
   logic [3:0]       r_lost_cnt;
   logic [3:0]       w_lost_cnt;
   logic             w_lock_s;

   sync2 u_lock_sync (
      .clk   (clk25),
      .rst_n (rst_n),
      .i_d   (bus.lock),
      .o_q   (w_lock_s)
   );

   // State and registered outputs; reset forces every domain into reset.
   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= WAIT_LOCK;
         r_cnt      <= '0;
         r_stage    <= '0;
         r_rst_out  <= '1;
         r_ready    <= 1'b0;
         r_lost_cnt <= '0;
      end else begin
         r_state    <= w_state;
         r_cnt      <= w_cnt;
         r_stage    <= w_stage;
         r_rst_out  <= w_rst_out;
         r_ready    <= w_ready;
         r_lost_cnt <= w_lost_cnt;
      end
   end

   // Next state and next output values; lock loss is tested before the soft
   // request so it wins when both arrive together.
   always_comb begin
      w_state    = r_state;
      w_cnt      = r_cnt;
      w_stage    = r_stage;
      w_rst_out  = r_rst_out;
      w_ready    = r_ready;
      w_lost_cnt = r_lost_cnt;

      if (r_state != WAIT_LOCK && !w_lock_s) begin
         w_state    = WAIT_LOCK;
         w_cnt      = '0;
         w_stage    = '0;
         w_rst_out  = '1;
         w_ready    = 1'b0;
         w_lost_cnt = sat_inc4(r_lost_cnt);
      end else if (r_state != WAIT_LOCK && bus.soft_rst) begin
         w_state   = SETTLE;
         w_cnt     = '0;
         w_stage   = '0;
         w_rst_out = '1;
         w_ready   = 1'b0;
      end else begin
         case (r_state)
            WAIT_LOCK: begin
               w_cnt     = '0;
               w_stage   = '0;
               w_rst_out = '1;
               w_ready   = 1'b0;
               if (w_lock_s) begin
                  w_state = SETTLE;
               end
            end
            SETTLE: begin
               if (r_cnt == SETTLE_LAST) begin
                  w_rst_out[0] = 1'b0;
                  w_cnt        = '0;
                  w_stage      = 4'd1;
                  if (N_OUT > 1) begin
                     w_state = RELEASE;
                  end else begin
                     w_state = RUN;
                     w_ready = 1'b1;
                  end
               end else begin
                  w_cnt = r_cnt + CNT_W'(1);
               end
            end
            RELEASE: begin
               if (r_cnt == STAGE_LAST) begin
                  for (int unsigned i = 0; i < N_OUT; i++) begin
                     if (4'(i) == r_stage) begin
                        w_rst_out[i] = 1'b0;
                     end
                  end
                  w_cnt   = '0;
                  w_stage = r_stage + 4'd1;
                  if (r_stage == LAST_STAGE) begin
                     w_state = RUN;
                     w_ready = 1'b1;
                  end
               end else begin
                  w_cnt = r_cnt + CNT_W'(1);
               end
            end
            RUN: begin
               w_cnt = '0;
            end
            default: begin
               w_state   = WAIT_LOCK;
               w_cnt     = '0;
               w_stage   = '0;
               w_rst_out = '1;
               w_ready   = 1'b0;
            end
         endcase
      end
   end

   assign bus.rst_out  = r_rst_out;
   assign bus.ready    = r_ready;
   assign bus.lost_cnt = r_lost_cnt;

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq: a default-parameter instance and a
// single-output, one-cycle-settle instance share clock and reset.
module tb_reset_seq;
   import sys_pkg::*;

   logic clk25;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   logic b_saw_release = 1'b0;

   reset_seq_if #(.N_OUT(2)) bus_a ();
   reset_seq_if #(.N_OUT(1)) bus_b ();

   reset_seq #(
      .N_OUT      (2),
      .CNT_W      (8),
      .SETTLE_CYC (16),
      .STAGE_CYC  (4)
   ) u_a (
      .clk25 (clk25),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   reset_seq #(
      .N_OUT      (1),
      .CNT_W      (8),
      .SETTLE_CYC (1),
      .STAGE_CYC  (4)
   ) u_b (
      .clk25 (clk25),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   initial begin
      clk25 = 1'b0;
      forever #20 clk25 = ~clk25;
   end

   // Record whether the single-output instance ever passes through RELEASE.
   always @(posedge clk25) begin
      if (u_b.r_state == RELEASE) b_saw_release <= 1'b1;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk25);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      bus_a.lock     = 1'b0;
      bus_a.soft_rst = 1'b0;
      bus_b.lock     = 1'b0;
      bus_b.soft_rst = 1'b0;
      step(2);
      check("reset_a_rst_out", 32'(bus_a.rst_out), 32'h3);
      check("reset_a_ready", 32'(bus_a.ready), 32'h0);
      check("reset_a_lost", 32'(bus_a.lost_cnt), 32'h0);
      check("reset_a_state", 32'(u_a.r_state), 32'(WAIT_LOCK));
      check("reset_b_rst_out", 32'(bus_b.rst_out), 32'h1);

      // Lock high while still in reset changes nothing.
      bus_a.lock = 1'b1;
      bus_b.lock = 1'b1;
      step(1);
      check("hold_in_reset", 32'(bus_a.rst_out), 32'h3);

      // Release reset: the next rising edge is edge k sampling lock high.
      rst_n = 1'b1;
      step(3);
      check("b_k2_rst_out", 32'(bus_b.rst_out), 32'h1);
      check("b_k2_ready", 32'(bus_b.ready), 32'h0);
      step(1);
      check("b_k3_rst_out", 32'(bus_b.rst_out), 32'h0);
      check("b_k3_ready", 32'(bus_b.ready), 32'h1);
      step(14);
      check("a_k17_rst_out", 32'(bus_a.rst_out), 32'h3);
      step(1);
      check("a_k18_rst_out", 32'(bus_a.rst_out), 32'h2);
      check("a_k18_ready", 32'(bus_a.ready), 32'h0);
      step(3);
      check("a_k21_rst_out", 32'(bus_a.rst_out), 32'h2);
      step(1);
      check("a_k22_rst_out", 32'(bus_a.rst_out), 32'h0);
      check("a_k22_ready", 32'(bus_a.ready), 32'h1);
      check("a_k22_state", 32'(u_a.r_state), 32'(RUN));

      // One-cycle lock drop sampled at edge j while in RUN.
      bus_a.lock = 1'b0;
      step(1);
      bus_a.lock = 1'b1;
      step(1);
      check("drop_j1_rst_out", 32'(bus_a.rst_out), 32'h0);
      check("drop_j1_ready", 32'(bus_a.ready), 32'h1);
      step(1);
      check("drop_j2_rst_out", 32'(bus_a.rst_out), 32'h3);
      check("drop_j2_ready", 32'(bus_a.ready), 32'h0);
      check("drop_j2_lost", 32'(bus_a.lost_cnt), 32'h1);
      step(16);
      check("drop_j18_rst_out", 32'(bus_a.rst_out), 32'h3);
      step(1);
      check("drop_j19_rst_out", 32'(bus_a.rst_out), 32'h2);
      step(4);
      check("drop_j23_rst_out", 32'(bus_a.rst_out), 32'h0);
      check("drop_j23_ready", 32'(bus_a.ready), 32'h1);

      // Soft reset sampled at edge s while in RUN.
      bus_a.soft_rst = 1'b1;
      step(1);
      bus_a.soft_rst = 1'b0;
      check("soft_s0_rst_out", 32'(bus_a.rst_out), 32'h3);
      check("soft_s0_ready", 32'(bus_a.ready), 32'h0);
      check("soft_s0_lost", 32'(bus_a.lost_cnt), 32'h1);
      step(15);
      check("soft_s15_rst_out", 32'(bus_a.rst_out), 32'h3);
      step(1);
      check("soft_s16_rst_out", 32'(bus_a.rst_out), 32'h2);
      step(4);
      check("soft_s20_rst_out", 32'(bus_a.rst_out), 32'h0);
      check("soft_s20_ready", 32'(bus_a.ready), 32'h1);
      check("soft_s20_lost", 32'(bus_a.lost_cnt), 32'h1);

      // Asynchronous reset in the middle of RELEASE.
      bus_a.soft_rst = 1'b1;
      step(1);
      bus_a.soft_rst = 1'b0;
      step(17);
      check("mid_release_rst_out", 32'(bus_a.rst_out), 32'h2);
      check("mid_release_state", 32'(u_a.r_state), 32'(RELEASE));
      #5 rst_n = 1'b0;
      #1;
      check("async_rst_out", 32'(bus_a.rst_out), 32'h3);
      check("async_ready", 32'(bus_a.ready), 32'h0);
      check("async_lost", 32'(bus_a.lost_cnt), 32'h0);
      check("async_state", 32'(u_a.r_state), 32'(WAIT_LOCK));
      step(1);
      rst_n = 1'b1;
      step(20);
      check("rerun_k19_rst_out", 32'(bus_a.rst_out), 32'h2);

      // Lock loss and soft reset reach the FSM on the same edge in RELEASE.
      bus_a.lock = 1'b0;
      step(2);
      check("both_j1_rst_out", 32'(bus_a.rst_out), 32'h2);
      bus_a.soft_rst = 1'b1;
      step(1);
      bus_a.soft_rst = 1'b0;
      check("both_state", 32'(u_a.r_state), 32'(WAIT_LOCK));
      check("both_rst_out", 32'(bus_a.rst_out), 32'h3);
      check("both_lost", 32'(bus_a.lost_cnt), 32'h1);

      // Repeated loss events: 12 more, then 8 more, which must saturate.
      for (int i = 0; i < 12; i++) begin
         bus_a.lock = 1'b1;
         step(2);
         bus_a.lock = 1'b0;
         step(2);
      end
      step(2);
      check("lost_after_13", 32'(bus_a.lost_cnt), 32'hD);
      for (int i = 0; i < 8; i++) begin
         bus_a.lock = 1'b1;
         step(2);
         bus_a.lock = 1'b0;
         step(2);
      end
      step(2);
      check("lost_saturated", 32'(bus_a.lost_cnt), 32'hF);
      check("sat_rst_out", 32'(bus_a.rst_out), 32'h3);
      check("sat_ready", 32'(bus_a.ready), 32'h0);

      check("b_no_release", 32'(b_saw_release), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
